// File: rtl/mem_burst_reader.sv
// mem_burst_reader: burst read sequencer for mem_256x16. Issues one address
// per cycle on the selected port, limited by FIFO credit, captures the
// registered memory data into a small FIFO and streams it out valid/ready.
module mem_burst_reader #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              port_sel_in,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic              mem_port_sel,
   output logic [ADDR_W-1:0] mem_addr_a,
   output logic [ADDR_W-1:0] mem_addr_b,
   output logic              mem_req,
   input  logic [DATA_W-1:0] mem_data_q,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   // state | meaning
   // IDLE  | waiting for start (a zero-length request is acknowledged from here)
   // ISSUE | driving one new address per cycle while credit allows
   // DRAIN | all addresses issued, waiting for the last word to be accepted
   // FIN   | one-cycle done pulse
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

   localparam int LW   = ADDR_W + 1;
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = PW + 1;
   localparam int CW   = PW + 2;

   state_t               state_q, state_d;
   logic                 sel_q, sel_d;
   logic [LW-1:0]        len_q, len_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic                 req_q, req_d;
   logic                 req_last_q, req_last_d;
   logic                 vld_q, vld_d;
   logic                 vld_last_q, vld_last_d;
   logic                 zlen_q, zlen_d;
   logic [LW-1:0]        iss_cnt_q, iss_cnt_d;

   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;
   logic [DATA_W-1:0]    fifo_data_q [FIFO_DEPTH];
   logic [DATA_W-1:0]    fifo_data_d [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_last_q, fifo_last_d;

   logic                 push;
   logic                 pop;
   logic [CW-1:0]        occ_sum;
   logic                 credit_ok;
   logic                 issue_first;
   logic                 issue_next;
   logic                 issue;
   logic [LW-1:0]        len_cur;

   // Issue decision: occupancy plus reads still in the memory pipeline must
   // leave room for one more word; a pop at this edge frees its slot.
   always_comb begin
      push        = vld_q;
      pop         = (cnt_q != '0) && out_ready;
      occ_sum     = CW'(cnt_q) + CW'(vld_q) + CW'(req_q) - CW'(pop);
      credit_ok   = occ_sum < CW'(FIFO_DEPTH);
      issue_first = (state_q == IDLE) && start && !zlen_q && (len != '0);
      issue_next  = (state_q == ISSUE) && (iss_cnt_q < len_q) && credit_ok;
      issue       = issue_first || issue_next;
      len_cur     = issue_first ? len : len_q;
      if (issue_first) begin
         iss_cnt_d = LW'(1);
      end else begin
         iss_cnt_d = iss_cnt_q + LW'(issue_next);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            // zero-length request: one cycle of request latency, then FIN
            if (zlen_q) begin
               state_d = FIN;
            end else if (issue_first) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (iss_cnt_d == len_q) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && out_last) begin
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output / datapath next values: address bus, request pipeline, latches
   always_comb begin
      sel_d      = sel_q;
      len_d      = len_q;
      addr_d     = addr_q;
      req_d      = issue;
      req_last_d = issue && (iss_cnt_d == len_cur);
      vld_d      = req_q;
      vld_last_d = req_last_q;
      zlen_d     = (state_q == IDLE) && start && !zlen_q && (len == '0);
      if (issue_first) begin
         sel_d  = port_sel_in;
         len_d  = len;
         addr_d = base_addr;
      end else if (issue_next) begin
         addr_d = addr_q + ADDR_W'(1);
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q      <= 1'b0;
         len_q      <= '0;
         addr_q     <= '0;
         req_q      <= 1'b0;
         req_last_q <= 1'b0;
         vld_q      <= 1'b0;
         vld_last_q <= 1'b0;
         zlen_q     <= 1'b0;
         iss_cnt_q  <= '0;
      end else begin
         sel_q      <= sel_d;
         len_q      <= len_d;
         addr_q     <= addr_d;
         req_q      <= req_d;
         req_last_q <= req_last_d;
         vld_q      <= vld_d;
         vld_last_q <= vld_last_d;
         zlen_q     <= zlen_d;
         iss_cnt_q  <= iss_cnt_d;
      end
   end

   // FIFO next values: push the returned word with its last tag, pop on handshake
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fifo_data_d = fifo_data_q;
      fifo_last_d = fifo_last_q;
      if (push) begin
         fifo_data_d[wr_ptr_q] = mem_data_q;
         fifo_last_d[wr_ptr_q] = vld_last_q;
         wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      cnt_d = cnt_q + CNTW'(push) - CNTW'(pop);
   end

   // FIFO registers; storage is cleared so out_data reads 0 after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         fifo_last_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_q[i] <= '0;
         end
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         fifo_last_q <= fifo_last_d;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_q[i] <= fifo_data_d[i];
         end
      end
   end

   assign busy         = (state_q == ISSUE) || (state_q == DRAIN);
   assign done         = (state_q == FIN);
   assign mem_port_sel = sel_q;
   assign mem_addr_a   = sel_q ? '0 : addr_q;
   assign mem_addr_b   = sel_q ? addr_q : '0;
   assign mem_req      = req_q;
   assign out_valid    = (cnt_q != '0);
   assign out_data     = fifo_data_q[rd_ptr_q];
   assign out_last     = out_valid && fifo_last_q[rd_ptr_q];

endmodule
